// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, drives the instruction-bus
// request/response handshake and presents one fetched instruction at a time downstream.
module ifetch_ctrl #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic [63:0] pc,
    output logic [31:0] raw_instr,
    output logic        valid
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t      state, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] pend_q, pend_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & ~64'd3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pc_q    <= RESET_PC;
            pend_q  <= RESET_PC;
            instr_q <= '0;
        end else begin
            state   <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            instr_q <= instr_d;
        end
    end

    // ireq_addr is pc_q, so pc_q may only change on the edge that completes a request
    always_comb begin
        state_d = state;
        pc_d    = pc_q;
        pend_d  = pend_q;
        instr_d = instr_q;
        case (state)
            IDLE: state_d = REQ;
            REQ: begin
                if (iresp_data_ok && redirect_valid) begin
                    pc_d = redirect_tgt;
                end else if (iresp_data_ok) begin
                    instr_d = iresp_data;
                    state_d = HOLD;
                end else if (redirect_valid) begin
                    pend_d  = redirect_tgt;
                    state_d = DROP;
                end
            end
            DROP: begin
                if (iresp_data_ok) begin
                    pc_d    = redirect_valid ? redirect_tgt : pend_q;
                    state_d = REQ;
                end else if (redirect_valid) begin
                    pend_d = redirect_tgt;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = REQ;
                end else if (!stall) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ireq_valid = (state == REQ) || (state == DROP);
        ireq_addr  = pc_q;
        valid      = (state == HOLD);
        pc         = pc_q;
        raw_instr  = instr_q;
    end

    // A response with no request outstanding is a bus protocol violation
    data_ok_only_when_waiting: assert property (
        @(posedge clk) disable iff (!reset)
        iresp_data_ok |-> (state == REQ || state == DROP)
    );

endmodule
